uart_rx_ctrl: RTL

- FSM controller for the UART receiver.
- Sequences the oversampled datapath: data sampler, start checker, parity checker, stop checker and deserializer.
- Contains the edge/bit counters and generates the one-cycle check enables.
- Judges the frame from the registered check results and issues data_valid.
- Sits between RX_IN/prescale configuration and the RX datapath sub-blocks; runs in the RX (oversampled) clock domain.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_edge_bit_cnt.sv | 47 ++++
 rtl/uart_rx_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver controller.
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    // Majority result lands this many edges after the nominal bit centre.
    localparam int SAMPLE_OFS     = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter with bit counter carry; edge count wraps at wrap_val_i.
// Single-cycle update; clear has priority over enable.
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  cnt_en_i,
    input  logic                  cnt_clr_i,
    input  logic [PRESCALE_W-1:0] wrap_val_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic [3:0]            bit_cnt_o
);

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (cnt_clr_i) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (cnt_en_i) begin
            if (edge_q == wrap_val_i) begin
                edge_d = '0;
                bit_d  = bit_q + 4'd1;
            end else begin
                edge_d = edge_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver frame controller: sequences sampler/checkers/deserializer and judges the frame.
// Strobes decode directly from state and counters; UART_RX_ERR_FLAGS_EN adds sticky error flags.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  deser_en,
    output logic                  data_valid,
`ifdef UART_RX_ERR_FLAGS_EN
    output logic                  par_err_flag,
    output logic                  stp_err_flag,
    output logic                  glitch_flag,
`endif
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt
);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  load_cfg;
    logic                  cnt_clr;
    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] samp_pt;
    logic                  at_last;
    logic                  at_samp;

    // Frame configuration is frozen for the whole frame once START is entered.
    assign last_edge = presc_q - 1'b1;
    assign samp_pt   = (presc_q >> 1) + PRESCALE_W'(SAMPLE_OFS);
    assign at_last   = (edge_cnt == last_edge);
    assign at_samp   = (edge_cnt == samp_pt);

    always_comb begin
        state_d     = state_q;
        load_cfg    = 1'b0;
        dat_samp_en = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        deser_en    = 1'b0;
        data_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d  = START;
                    load_cfg = 1'b1;
                end
            end
            START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = at_samp;
                if (at_last) state_d = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = at_samp;
                if (at_last && (bit_cnt == 4'(DATA_WIDTH)))
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = at_samp;
                if (at_last) state_d = STOP;
            end
            STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = at_samp;
                // Leave right after the stop check so a following start bit is not missed.
                if (edge_cnt == samp_pt + 1'b1) state_d = DONE;
            end
            DONE: begin
                data_valid = !stp_err && !(par_en_q && par_err);
                if (!RX_IN) begin
                    state_d  = START;
                    load_cfg = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_clr  = (state_d == IDLE) || load_cfg;
    assign presc_d  = load_cfg ? Prescale : presc_q;
    assign par_en_d = load_cfg ? PAR_EN : par_en_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            par_en_q <= par_en_d;
        end
    end

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W)
    ) u_cnt (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .cnt_en_i   (state_q != IDLE),
        .cnt_clr_i  (cnt_clr),
        .wrap_val_i (last_edge),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt)
    );

`ifdef UART_RX_ERR_FLAGS_EN
    // A clean start bit opens a new frame and clears the previous frame's errors.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            par_err_flag <= 1'b0;
            stp_err_flag <= 1'b0;
            glitch_flag  <= 1'b0;
        end else begin
            if (state_q == START && at_last) begin
                if (strt_glitch) begin
                    glitch_flag <= 1'b1;
                end else begin
                    par_err_flag <= 1'b0;
                    stp_err_flag <= 1'b0;
                    glitch_flag  <= 1'b0;
                end
            end
            if (state_q == DONE) begin
                if (stp_err)             stp_err_flag <= 1'b1;
                if (par_en_q && par_err) par_err_flag <= 1'b1;
            end
        end
    end
`endif

endmodule
